// File: rtl/hex_sr_pkg.sv
// ============================================================================
// Module : hex_sr_pkg
// Brief  : Shared types and defaults for the hex shift-register controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_sr_pkg;

  localparam int DEFAULT_LENGTH = 62;
  localparam int DEFAULT_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sr_pos_counter.sv
// ============================================================================
// Module : sr_pos_counter
// Brief  : Modulo-LENGTH counter naming the word currently at the SR output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_pos_counter #(
  parameter int LENGTH = 62,
  parameter int AW     = $clog2(LENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] pos
);

  localparam logic [AW-1:0] c_last_pos = AW'(LENGTH - 1);

  logic [AW-1:0] r_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
    end else if (r_pos == c_last_pos) begin
      r_pos <= '0;
    end else begin
      r_pos <= r_pos + 1'b1;
    end
  end

  assign pos = r_pos;

endmodule

`default_nettype wire

// File: rtl/hex_sr_ctrl.sv
// ============================================================================
// Module : hex_sr_ctrl
// Brief  : Random-access read/write controller for a recirculating SR memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_sr_ctrl
  import hex_sr_pkg::*;
#(
  parameter  int LENGTH         = DEFAULT_LENGTH,
  parameter  int WIDTH          = DEFAULT_WIDTH,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AW             = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             sr_recirc,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic [AW-1:0]    pos
);

  localparam state_t        c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [AW-1:0] c_last_pos    = AW'(LENGTH - 1);
  localparam logic [AW:0]   c_length      = (AW+1)'(LENGTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_write;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic             w_accept;
  logic             w_addr_bad;
  logic             w_hit;

  sr_pos_counter #(
    .LENGTH (LENGTH),
    .AW     (AW)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .pos (pos)
  );

  assign w_accept   = req_valid & req_ready;
  assign w_addr_bad = ({1'b0, req_addr} >= c_length);
  assign w_hit      = (r_state == ST_WAIT) && (pos == r_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_reset_state;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SR drive depends only on state, position and latched fields, never on sr_data_out.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    sr_recirc   = 1'b1;
    sr_data_in  = '0;
    case (r_state)
      ST_CLEAR: begin
        sr_recirc = 1'b0;
        if (pos == c_last_pos) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_addr_bad ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_hit) begin
          if (r_write) begin
            sr_recirc  = 1'b0;
            sr_data_in = r_wdata;
          end
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        rsp_err     = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = c_reset_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_addr_bad;
        r_rdata <= '0;
      end
      if (w_hit && !r_write) begin
        r_rdata <= sr_data_out;
      end
    end
  end

  assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire
